// File: rtl/line_clear_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : line_clear_ctrl                                            |
// | Description : Board-row memory sequencer run after a piece lands. It     |
// |               merges the four piece cells into the board, compacts full  |
// |               rows bottom-up, zero-fills the top and then pulses done.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module line_clear_ctrl #(
   parameter int ROWS   = 20,
   parameter int COLS   = 10,
   parameter int CELL_W = 3,
   parameter int AW     = 5
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     restart,
   input  logic                     lock_req,
   input  logic [19:0]              lock_x,
   input  logic [19:0]              lock_y,
   input  logic [CELL_W-1:0]        lock_color,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               lines_cleared,
   output logic [15:0]              total_lines,
   output logic                     top_out,
   output logic [AW-1:0]            row_addr,
   output logic                     row_re,
   input  logic [COLS*CELL_W-1:0]   row_rdata,
   output logic                     row_we,
   output logic [COLS*CELL_W-1:0]   row_wdata
);

   localparam logic [4:0] c_COLS5 = 5'(COLS);
   localparam logic [4:0] c_ROWS5 = 5'(ROWS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRD  = 3'd1,
      S_PWR  = 3'd2,
      S_SRD  = 3'd3,
      S_SEV  = 3'd4,
      S_FILL = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t                r_state;
   logic [19:0]           r_x;
   logic [19:0]           r_y;
   logic [CELL_W-1:0]     r_color;
   logic [1:0]            r_idx;
   logic [4:0]            r_col;
   logic                  r_cell_ok;
   logic [AW-1:0]         r_rd;
   logic [AW-1:0]         r_wr;
   logic [AW-1:0]         r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic [2:0]            r_lines;
   logic [15:0]           r_total;
   logic                  r_top;
   logic [AW-1:0]         r_row_addr;
   logic                  r_row_re;

   logic [19:0]           w_src_x;
   logic [19:0]           w_src_y;
   logic [1:0]            w_nidx;
   logic [4:0]            w_cx;
   logic [4:0]            w_cy;
   logic                  w_cok;
   logic [AW-1:0]         w_caddr;
   logic                  w_full;
   logic [COLS*CELL_W-1:0] w_merged;
   logic [AW-1:0]         w_cnt_nxt;
   logic [16:0]           w_sum;
   logic [15:0]           w_total_sat;

   assign busy          = r_busy;
   assign done          = r_done;
   assign lines_cleared = r_lines;
   assign total_lines   = r_total;
   assign top_out       = r_top;
   assign row_addr      = r_row_addr;
   assign row_re        = r_row_re;

   // Select the next piece cell: cell 0 straight from the inputs at accept, later cells from the latched copy
   always_comb begin
      w_src_x = (r_state == S_IDLE) ? lock_x : r_x;
      w_src_y = (r_state == S_IDLE) ? lock_y : r_y;
      w_nidx  = (r_state == S_IDLE) ? 2'd0 : (r_idx + 2'd1);
      case (w_nidx)
         2'd0:    begin w_cx = w_src_x[4:0];   w_cy = w_src_y[4:0];   end
         2'd1:    begin w_cx = w_src_x[9:5];   w_cy = w_src_y[9:5];   end
         2'd2:    begin w_cx = w_src_x[14:10]; w_cy = w_src_y[14:10]; end
         default: begin w_cx = w_src_x[19:15]; w_cy = w_src_y[19:15]; end
      endcase
      w_cok   = (w_cx < c_COLS5) && (w_cy < c_ROWS5);
      w_caddr = AW'(w_cy);
   end

   // Row full detection and piece-cell merge on the returned read data
   always_comb begin
      w_full   = 1'b1;
      w_merged = row_rdata;
      for (int c = 0; c < COLS; c++) begin
         if (row_rdata[c*CELL_W +: CELL_W] == '0) w_full = 1'b0;
         if (r_col == 5'(c)) w_merged[c*CELL_W +: CELL_W] = r_color;
      end
   end

   // Row count including the row under evaluation, and the saturating running total
   always_comb begin
      w_cnt_nxt   = r_cnt + {{(AW-1){1'b0}}, w_full};
      w_sum       = {1'b0, r_total} + {{(17-AW){1'b0}}, r_cnt};
      w_total_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];
   end

   // Write strobe and data depend on the same-cycle read data (1-cycle RAM read latency, 2-cycle budget)
   always_comb begin
      row_we    = 1'b0;
      row_wdata = '0;
      case (r_state)
         S_PWR: begin
            row_we = r_cell_ok;
            if (r_cell_ok) row_wdata = w_merged;
         end
         S_SEV: begin
            row_we = ~w_full;
            if (!w_full) row_wdata = row_rdata;
         end
         S_FILL: begin
            row_we = 1'b1;
         end
         default: begin
            row_we = 1'b0;
         end
      endcase
   end

   // Sequencer: merge piece, scan/compact rows, zero-fill the top, report
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_color    <= '0;
         r_idx      <= '0;
         r_col      <= '0;
         r_cell_ok  <= 1'b0;
         r_rd       <= '0;
         r_wr       <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_lines    <= '0;
         r_total    <= '0;
         r_top      <= 1'b0;
         r_row_addr <= '0;
         r_row_re   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (restart) begin
                  r_total <= '0;
                  r_top   <= 1'b0;
               end
               if (lock_req) begin
                  r_x        <= lock_x;
                  r_y        <= lock_y;
                  r_color    <= lock_color;
                  r_idx      <= 2'd0;
                  r_rd       <= AW'(ROWS-1);
                  r_wr       <= AW'(ROWS-1);
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_cell_ok  <= w_cok;
                  r_col      <= w_cx;
                  r_row_re   <= w_cok;
                  r_row_addr <= w_caddr;
                  r_state    <= S_PRD;
               end
            end
            S_PRD: begin
               r_row_re <= 1'b0;
               r_state  <= S_PWR;
            end
            S_PWR: begin
               if (r_idx == 2'd3) begin
                  r_row_re   <= 1'b1;
                  r_row_addr <= r_rd;
                  r_state    <= S_SRD;
               end else begin
                  r_idx      <= r_idx + 2'd1;
                  r_cell_ok  <= w_cok;
                  r_col      <= w_cx;
                  r_row_re   <= w_cok;
                  r_row_addr <= w_caddr;
                  r_state    <= S_PRD;
               end
            end
            S_SRD: begin
               r_row_re   <= 1'b0;
               r_row_addr <= r_wr;
               r_state    <= S_SEV;
            end
            S_SEV: begin
               if (w_full) begin
                  r_cnt <= w_cnt_nxt;
               end else begin
                  r_wr <= r_wr - AW'(1);
                  if ((r_wr == '0) && (row_rdata != '0)) r_top <= 1'b1;
               end
               r_rd <= r_rd - AW'(1);
               if (r_rd == '0) begin
                  if (w_cnt_nxt == '0) begin
                     // Nothing cleared: no fill rows, report directly
                     r_done  <= 1'b1;
                     r_lines <= 3'd0;
                     r_state <= S_DONE;
                  end else begin
                     // Surviving rows end at row cnt, so the fill covers cnt-1 .. 0
                     r_wr       <= w_cnt_nxt - AW'(1);
                     r_row_addr <= w_cnt_nxt - AW'(1);
                     r_state    <= S_FILL;
                  end
               end else begin
                  r_row_re   <= 1'b1;
                  r_row_addr <= r_rd - AW'(1);
                  r_state    <= S_SRD;
               end
            end
            S_FILL: begin
               if (r_wr == '0) begin
                  r_done  <= 1'b1;
                  r_lines <= r_cnt[2:0];
                  r_total <= w_total_sat;
                  r_state <= S_DONE;
               end else begin
                  r_wr       <= r_wr - AW'(1);
                  r_row_addr <= r_wr - AW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_line_clear_ctrl                                         |
// | Description : Self-checking bench for line_clear_ctrl with a board RAM   |
// |               model and a board-level behavioural reference.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_line_clear_ctrl;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int CW   = 3;
   localparam int AW   = 5;
   localparam int RW   = COLS*CW;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          restart = 1'b0;
   logic          lock_req = 1'b0;
   logic [19:0]   lock_x = '0;
   logic [19:0]   lock_y = '0;
   logic [2:0]    lock_color = '0;
   logic          busy, done, top_out, row_re, row_we;
   logic [2:0]    lines_cleared;
   logic [15:0]   total_lines;
   logic [AW-1:0] row_addr;
   logic [RW-1:0] row_rdata = '0;
   logic [RW-1:0] row_wdata;

   logic [RW-1:0] ram [ROWS];
   logic [RW-1:0] pre [ROWS];
   logic          load_en = 1'b0;

   logic [2:0]    mdl [ROWS][COLS];
   int            exp_cnt = 0;
   bit            exp_top = 1'b0;

   int            n_chk = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            n_done = 0, n_re = 0, n_we = 0;

   bit            m_active = 1'b0;
   int            m_age = 0;
   int            m_lat = 0;
   logic [2:0]    m_lines = '0;
   logic [15:0]   m_total = '0;
   bit            m_top = 1'b0;

   always #5 Clk = ~Clk;

   line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CW), .AW(AW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .restart(restart), .lock_req(lock_req),
      .lock_x(lock_x), .lock_y(lock_y), .lock_color(lock_color),
      .busy(busy), .done(done), .lines_cleared(lines_cleared),
      .total_lines(total_lines), .top_out(top_out), .row_addr(row_addr),
      .row_re(row_re), .row_rdata(row_rdata), .row_we(row_we), .row_wdata(row_wdata)
   );

   // Board RAM: synchronous write, read data valid the cycle after row_re
   always @(posedge Clk) begin
      if (load_en) begin
         for (int r = 0; r < ROWS; r++) ram[r] <= pre[r];
      end else begin
         if (row_we && int'(row_addr) < ROWS) ram[row_addr] <= row_wdata;
         if (row_re && int'(row_addr) < ROWS) row_rdata <= ram[row_addr];
      end
   end

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (Reset_n) begin
         n_done <= n_done + int'(done);
         n_re   <= n_re + int'(row_re);
         n_we   <= n_we + int'(row_we);
      end
   end

   function automatic logic [15:0] sat16(input logic [15:0] t, input int c);
      int s;
      s = int'(t) + c;
      return (s > 65535) ? 16'hFFFF : 16'(s);
   endfunction

   // Timing model: accepted lock_req -> busy for 49+cnt cycles, done in the last one
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_lines  <= '0;
         m_total  <= '0;
         m_top    <= 1'b0;
      end else if (m_active) begin
         if (m_age == m_lat) begin
            m_active <= 1'b0;
         end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) begin
               m_lines <= 3'(exp_cnt);
               m_total <= sat16(m_total, exp_cnt);
               m_top   <= m_top | exp_top;
            end
         end
      end else begin
         if (restart) begin
            m_total <= '0;
            m_top   <= 1'b0;
         end
         if (lock_req) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_lat    <= 8 + 2*ROWS + exp_cnt + 1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(negedge Clk) begin
      if (Reset_n) begin
         check("busy", 32'(busy), 32'(m_active));
         check("done", 32'(done), 32'(m_active && (m_age == m_lat)));
         check("re_we_excl", 32'(row_re & row_we), 32'd0);
         if (!m_active) check("idle_port", 32'(row_re | row_we), 32'd0);
         check("lines_cleared", 32'(lines_cleared), 32'(m_lines));
         check("total_lines", 32'(total_lines), 32'(m_total));
         check("top_out", 32'(top_out), 32'(m_top));
      end
   end

   function automatic logic [RW-1:0] pack_row(input int r);
      logic [RW-1:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++) v[c*CW +: CW] = mdl[r][c];
      return v;
   endfunction

   task automatic clear_mdl();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mdl[r][c] = 3'd0;
   endtask

   task automatic load_board();
      for (int r = 0; r < ROWS; r++) pre[r] = pack_row(r);
      @(negedge Clk); load_en = 1'b1;
      @(negedge Clk); load_en = 1'b0;
   endtask

   // Board-level reference: drop piece, remove full rows, let the rest fall, empty rows on top
   task automatic predict(input logic [19:0] px, input logic [19:0] py, input logic [2:0] col);
      logic [2:0] nb [ROWS][COLS];
      int dst, cnt;
      bit full;
      for (int i = 0; i < 4; i++) begin
         int x, y;
         x = int'(px[5*i +: 5]);
         y = int'(py[5*i +: 5]);
         if (x < COLS && y < ROWS) mdl[y][x] = col;
      end
      cnt = 0;
      dst = ROWS-1;
      for (int r = ROWS-1; r >= 0; r--) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++) if (mdl[r][c] == 3'd0) full = 1'b0;
         if (full) cnt++;
         else begin
            for (int c = 0; c < COLS; c++) nb[dst][c] = mdl[r][c];
            dst--;
         end
      end
      for (int r = dst; r >= 0; r--)
         for (int c = 0; c < COLS; c++) nb[r][c] = 3'd0;
      mdl     = nb;
      exp_cnt = cnt;
      exp_top = (pack_row(0) != '0);
   endtask

   task automatic pulse_lock(input logic [19:0] px, input logic [19:0] py,
                             input logic [2:0] col, input bit rs, output int st);
      @(negedge Clk);
      lock_x = px; lock_y = py; lock_color = col; lock_req = 1'b1; restart = rs;
      st = cyc;
      @(negedge Clk);
      lock_req = 1'b0; restart = 1'b0;
   endtask

   task automatic wait_done(input int st, output int lat);
      for (int k = 0; k < 200 && done !== 1'b1; k++) @(negedge Clk);
      if (done !== 1'b1) begin
         n_chk++; n_fail++;
         $display("FAIL done_timeout: got done=%0b expected 1 within 200 cycles", done);
      end
      lat = cyc - st;
   endtask

   task automatic check_board(input string nm);
      for (int r = 0; r < ROWS; r++) check($sformatf("%s_row%0d", nm, r), 32'(ram[r]), 32'(pack_row(r)));
   endtask

   task automatic run_piece(input logic [19:0] px, input logic [19:0] py, input logic [2:0] col,
                            input bit rs, input string nm, output int lat);
      int st;
      predict(px, py, col);
      pulse_lock(px, py, col, rs, st);
      wait_done(st, lat);
      repeat (2) @(negedge Clk);
      check_board(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, st, b_re, b_we, b_done;

      // Reset values
      repeat (3) @(negedge Clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_re", 32'(row_re), 32'd0);
      check("rst_we", 32'(row_we), 32'd0);
      check("rst_addr", 32'(row_addr), 32'd0);
      check("rst_wdata", 32'(row_wdata), 32'd0);
      check("rst_lines", 32'(lines_cleared), 32'd0);
      check("rst_total", 32'(total_lines), 32'd0);
      check("rst_top", 32'(top_out), 32'd0);
      Reset_n = 1'b1;

      // T piece on empty board
      clear_mdl(); load_board();
      run_piece({5'd6, 5'd5, 5'd5, 5'd4}, {5'd1, 5'd1, 5'd0, 5'd1}, 3'd5, 1'b0, "t1", lat);
      check("t1_latency", 32'(lat), 32'd49);
      check("t1_row0", 32'(ram[0]), 32'h0002_8000);
      check("t1_row1", 32'(ram[1]), 32'h0016_D000);
      check("t1_lines", 32'(lines_cleared), 32'd0);

      // One row completed by a horizontal I
      clear_mdl();
      for (int c = 0; c < 6; c++) mdl[19][c] = 3'd1;
      mdl[18][0] = 3'd2;
      load_board();
      run_piece({5'd9, 5'd8, 5'd7, 5'd6}, {5'd19, 5'd19, 5'd19, 5'd19}, 3'd6, 1'b0, "t2", lat);
      check("t2_latency", 32'(lat), 32'd50);
      check("t2_lines", 32'(lines_cleared), 32'd1);
      check("t2_row19", 32'(ram[19]), 32'd2);
      check("t2_row0", 32'(ram[0]), 32'd0);
      check("t2_total", 32'(total_lines), 32'd1);

      // Four rows by a vertical I, restart in the same cycle as lock_req
      clear_mdl();
      for (int r = 16; r < 20; r++)
         for (int c = 0; c < 9; c++) mdl[r][c] = 3'd4;
      load_board();
      run_piece({5'd9, 5'd9, 5'd9, 5'd9}, {5'd19, 5'd18, 5'd17, 5'd16}, 3'd3, 1'b1, "t3", lat);
      check("t3_latency", 32'(lat), 32'd53);
      check("t3_lines", 32'(lines_cleared), 32'd4);
      check("t3_total", 32'(total_lines), 32'd4);
      check("t3_row3", 32'(ram[3]), 32'd0);

      // Out-of-range cell skipped
      clear_mdl(); load_board();
      b_re = n_re; b_we = n_we;
      run_piece({5'd5, 5'd4, 5'd12, 5'd3}, {5'd10, 5'd10, 5'd10, 5'd10}, 3'd7, 1'b0, "t4", lat);
      check("t4_latency", 32'(lat), 32'd49);
      check("t4_row10", 32'(ram[10]), 32'h0003_FE00);
      check("t4_reads", 32'(n_re - b_re), 32'd23);
      check("t4_writes", 32'(n_we - b_we), 32'd23);

      // Top-out: every row non-full, row 0 occupied
      clear_mdl();
      for (int r = 0; r < ROWS; r++) mdl[r][0] = 3'd1;
      load_board();
      run_piece({5'd4, 5'd3, 5'd2, 5'd1}, {5'd19, 5'd19, 5'd19, 5'd19}, 3'd3, 1'b0, "t5a", lat);
      check("t5_top_set", 32'(top_out), 32'd1);
      run_piece({5'd5, 5'd5, 5'd5, 5'd5}, {5'd10, 5'd10, 5'd10, 5'd10}, 3'd2, 1'b0, "t5b", lat);
      check("t5_top_sticky", 32'(top_out), 32'd1);
      @(negedge Clk); restart = 1'b1;
      @(negedge Clk); restart = 1'b0;
      @(negedge Clk);
      check("t5_top_restart", 32'(top_out), 32'd0);
      check("t5_total_restart", 32'(total_lines), 32'd0);

      // Second lock_req while busy is ignored
      clear_mdl(); load_board();
      b_done = n_done;
      predict({5'd1, 5'd1, 5'd0, 5'd0}, {5'd19, 5'd18, 5'd19, 5'd18}, 3'd1);
      pulse_lock({5'd1, 5'd1, 5'd0, 5'd0}, {5'd19, 5'd18, 5'd19, 5'd18}, 3'd1, 1'b0, st);
      repeat (4) @(negedge Clk);
      lock_req = 1'b1;
      @(negedge Clk); lock_req = 1'b0;
      wait_done(st, lat);
      check("t6_latency", 32'(lat), 32'd49);
      repeat (60) @(negedge Clk);
      check("t6_single_done", 32'(n_done - b_done), 32'd1);
      check_board("t6");

      // Asynchronous reset in the middle of the row scan
      clear_mdl(); load_board();
      predict({5'd2, 5'd2, 5'd2, 5'd2}, {5'd5, 5'd5, 5'd5, 5'd5}, 3'd4);
      pulse_lock({5'd2, 5'd2, 5'd2, 5'd2}, {5'd5, 5'd5, 5'd5, 5'd5}, 3'd4, 1'b0, st);
      for (int k = 0; k < 100 && (cyc - st) < 20; k++) @(negedge Clk);
      check("t7_busy_pre", 32'(busy), 32'd1);
      check("t7_we_pre", 32'(row_we), 32'd1);
      #1 Reset_n = 1'b0;
      #1;
      check("t7_busy_async", 32'(busy), 32'd0);
      check("t7_we_async", 32'(row_we), 32'd0);
      check("t7_re_async", 32'(row_re), 32'd0);
      @(negedge Clk); Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      check("t7_idle_after", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
